cond_exec_stage: RTL and testbench

COND_EXEC_STAGE -- requirements
Module: cond_exec_stage

---
 rtl/alu_params.sv | 11 +
 rtl/cond_exec_stage_pkg.sv | 50 +++++
 rtl/cond_exec_stage_cond_check.sv | 39 +++
 rtl/cond_exec_stage.sv | 132 +++++++++++++
 tb/tb_cond_exec_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_params.sv
// ALU operation codes shared by the decoder, the ALU and the execute stage.
package alu_params;

    localparam logic [3:0] ALU_NOP    = 4'd0;
    localparam logic [3:0] ALU_ADD    = 4'd1;
    localparam logic [3:0] ALU_SUB    = 4'd2;
    localparam logic [3:0] ALU_MULT   = 4'd3;
    localparam logic [3:0] ALU_BUFFER = 4'd4;
    localparam logic [3:0] ALU_AV     = 4'd5;

endpackage

// File: rtl/cond_exec_stage_pkg.sv
// Condition codes, NZCV bit positions and the execute control bundle.
package cond_exec_stage_pkg;

    import alu_params::*;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef struct packed {
        logic       valid;
        logic [3:0] cond;
        logic       alu_src;
        logic       mem_to_reg;
        logic       reg_write;
        logic       plus_one;
        logic       branch;
        logic       pc_src;
        logic       mem_write;
        logic [3:0] alu_control;
        logic [1:0] flag_w;
    } ex_ctrl_t;

    // A bubble never executes: always-true condition so it cannot count as squashed.
    function automatic ex_ctrl_t ex_bubble();
        ex_ctrl_t b;
        b             = '0;
        b.cond        = COND_AL;
        b.alu_control = ALU_NOP;
        return b;
    endfunction

endpackage

// File: rtl/cond_exec_stage_cond_check.sv
// Combinational ARM condition evaluation of a 4-bit cond field against NZCV.
module cond_check
    import cond_exec_stage_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       ok_o
);

    logic n, z, c, v;

    assign n = flags_i[FLAG_N];
    assign z = flags_i[FLAG_Z];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    always_comb begin
        ok_o = 1'b0;
        case (cond_i)
            COND_EQ: ok_o = z;
            COND_NE: ok_o = !z;
            COND_CS: ok_o = c;
            COND_CC: ok_o = !c;
            COND_MI: ok_o = n;
            COND_PL: ok_o = !n;
            COND_VS: ok_o = v;
            COND_VC: ok_o = !v;
            COND_HI: ok_o = c && !z;
            COND_LS: ok_o = !c || z;
            COND_GE: ok_o = (n == v);
            COND_LT: ok_o = (n != v);
            COND_GT: ok_o = !z && (n == v);
            COND_LE: ok_o = z || (n != v);
            COND_AL: ok_o = 1'b1;
            default: ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_exec_stage.sv
// Execute-stage control register with conditional execution and NZCV flag register.
// Define PERF_CNT_EN to add the saturating squashed-instruction counter (squash_cnt).
module cond_exec_stage
    import cond_exec_stage_pkg::*;
    import alu_params::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall_e,
    input  logic        flush_e,
    input  logic        valid_d,
    input  logic [3:0]  cond_d,
    input  logic        alu_src_d,
    input  logic        mem_to_reg_d,
    input  logic        reg_write_d,
    input  logic        plus_one_d,
    input  logic        branch_d,
    input  logic        pc_src_d,
    input  logic        mem_write_d,
    input  logic [3:0]  alu_control_d,
    input  logic [1:0]  flag_w_d,
    input  logic [3:0]  alu_flags_e,
    output logic        alu_src_e,
    output logic        mem_to_reg_e,
    output logic        plus_one_e,
    output logic [3:0]  alu_control_e,
    output logic        reg_write_g,
    output logic        mem_write_g,
    output logic        pc_src_g,
    output logic        branch_taken_e,
    output logic        cond_ok_e,
`ifdef PERF_CNT_EN
    output logic [15:0] squash_cnt,
`endif
    output logic [3:0]  flags_q
);

    ex_ctrl_t   ex_q, ex_d;
    logic [3:0] flags_d;
    logic       commit;
    logic       advance;

    always_comb begin
        ex_d = ex_q;
        if (flush_e) begin
            ex_d = ex_bubble();
        end else if (!stall_e) begin
            ex_d.valid       = valid_d;
            ex_d.cond        = cond_d;
            ex_d.alu_src     = alu_src_d;
            ex_d.mem_to_reg  = mem_to_reg_d;
            ex_d.reg_write   = reg_write_d;
            ex_d.plus_one    = plus_one_d;
            ex_d.branch      = branch_d;
            ex_d.pc_src      = pc_src_d;
            ex_d.mem_write   = mem_write_d;
            ex_d.alu_control = alu_control_d;
            ex_d.flag_w      = flag_w_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_q <= ex_bubble();
        end else begin
            ex_q <= ex_d;
        end
    end

    cond_check u_cond_check (
        .cond_i  (ex_q.cond),
        .flags_i (flags_q),
        .ok_o    (cond_ok_e)
    );

    assign commit  = ex_q.valid && cond_ok_e;
    // A stalled instruction stays in execute, so it must not retire its flags yet.
    assign advance = !stall_e;

    assign alu_src_e      = ex_q.alu_src;
    assign mem_to_reg_e   = ex_q.mem_to_reg;
    assign plus_one_e     = ex_q.plus_one;
    assign alu_control_e  = ex_q.alu_control;
    assign reg_write_g    = commit && ex_q.reg_write;
    assign mem_write_g    = commit && ex_q.mem_write;
    assign pc_src_g       = commit && ex_q.pc_src;
    assign branch_taken_e = commit && ex_q.branch;

    always_comb begin
        flags_d = flags_q;
        if (commit && advance) begin
            if (ex_q.flag_w[1]) begin
                flags_d[FLAG_N] = alu_flags_e[FLAG_N];
                flags_d[FLAG_Z] = alu_flags_e[FLAG_Z];
            end
            if (ex_q.flag_w[0]) begin
                flags_d[FLAG_C] = alu_flags_e[FLAG_C];
                flags_d[FLAG_V] = alu_flags_e[FLAG_V];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags_q <= 4'b0000;
        end else begin
            flags_q <= flags_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [15:0] squash_cnt_q, squash_cnt_d;

    always_comb begin
        squash_cnt_d = squash_cnt_q;
        if (advance && ex_q.valid && !cond_ok_e && (squash_cnt_q != 16'hFFFF)) begin
            squash_cnt_d = squash_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            squash_cnt_q <= 16'd0;
        end else begin
            squash_cnt_q <= squash_cnt_d;
        end
    end

    assign squash_cnt = squash_cnt_q;
`endif

endmodule

// File: tb/tb_cond_exec_stage.sv
// Directed scoreboard bench for cond_exec_stage; counter checks run when PERF_CNT_EN is defined.
module tb_cond_exec_stage;
    import alu_params::*;
    import cond_exec_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_e, flush_e, valid_d;
    logic [3:0]  cond_d;
    logic        alu_src_d, mem_to_reg_d, reg_write_d, plus_one_d, branch_d, pc_src_d, mem_write_d;
    logic [3:0]  alu_control_d;
    logic [1:0]  flag_w_d;
    logic [3:0]  alu_flags_e;
    logic        alu_src_e, mem_to_reg_e, plus_one_e;
    logic [3:0]  alu_control_e;
    logic        reg_write_g, mem_write_g, pc_src_g, branch_taken_e, cond_ok_e;
    logic [3:0]  flags_q;
`ifdef PERF_CNT_EN
    logic [15:0] squash_cnt;
`endif

    always #5 clk = ~clk;

    cond_exec_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall_e        (stall_e),
        .flush_e        (flush_e),
        .valid_d        (valid_d),
        .cond_d         (cond_d),
        .alu_src_d      (alu_src_d),
        .mem_to_reg_d   (mem_to_reg_d),
        .reg_write_d    (reg_write_d),
        .plus_one_d     (plus_one_d),
        .branch_d       (branch_d),
        .pc_src_d       (pc_src_d),
        .mem_write_d    (mem_write_d),
        .alu_control_d  (alu_control_d),
        .flag_w_d       (flag_w_d),
        .alu_flags_e    (alu_flags_e),
        .alu_src_e      (alu_src_e),
        .mem_to_reg_e   (mem_to_reg_e),
        .plus_one_e     (plus_one_e),
        .alu_control_e  (alu_control_e),
        .reg_write_g    (reg_write_g),
        .mem_write_g    (mem_write_g),
        .pc_src_g       (pc_src_g),
        .branch_taken_e (branch_taken_e),
        .cond_ok_e      (cond_ok_e),
`ifdef PERF_CNT_EN
        .squash_cnt     (squash_cnt),
`endif
        .flags_q        (flags_q)
    );

    typedef struct {
        string      tag;
        logic [3:0] flags;
        logic       ok, rw, mw, pcs, bt;
        logic [3:0] aluc;
        logic       asrc, m2r, p1;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_dec(input logic v, input logic [3:0] cond, input logic [3:0] aluc,
                           input logic [1:0] fw, input logic asrc, input logic m2r,
                           input logic rw, input logic p1, input logic br,
                           input logic pcs, input logic mw);
        valid_d = v;        cond_d = cond;       alu_control_d = aluc; flag_w_d = fw;
        alu_src_d = asrc;   mem_to_reg_d = m2r;  reg_write_d = rw;     plus_one_d = p1;
        branch_d = br;      pc_src_d = pcs;      mem_write_d = mw;
    endtask

    task automatic expect_e(input string tag, input logic [3:0] fl, input logic ok,
                            input logic rw, input logic mw, input logic pcs, input logic bt,
                            input logic [3:0] aluc, input logic asrc, input logic m2r,
                            input logic p1);
        exp_t e;
        e.tag = tag; e.flags = fl; e.ok = ok; e.rw = rw; e.mw = mw; e.pcs = pcs;
        e.bt = bt; e.aluc = aluc; e.asrc = asrc; e.m2r = m2r; e.p1 = p1;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tick_check();
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("scoreboard_empty", 16'(sb.size()), 16'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".flags"},    16'(flags_q),        16'(e.flags));
            check({e.tag, ".cond_ok"},  16'(cond_ok_e),      16'(e.ok));
            check({e.tag, ".reg_wr_g"}, 16'(reg_write_g),    16'(e.rw));
            check({e.tag, ".mem_wr_g"}, 16'(mem_write_g),    16'(e.mw));
            check({e.tag, ".pc_src_g"}, 16'(pc_src_g),       16'(e.pcs));
            check({e.tag, ".br_taken"}, 16'(branch_taken_e), 16'(e.bt));
            check({e.tag, ".alu_ctl"},  16'(alu_control_e),  16'(e.aluc));
            check({e.tag, ".alu_src"},  16'(alu_src_e),      16'(e.asrc));
            check({e.tag, ".mem2reg"},  16'(mem_to_reg_e),   16'(e.m2r));
            check({e.tag, ".plus1"},    16'(plus_one_e),     16'(e.p1));
        end
    endtask

    logic [3:0]  fv [4];
    logic [15:0] mk [4];
    logic [15:0] m;

    initial begin
        fv[0] = 4'b0000; mk[0] = 16'h56AA;
        fv[1] = 4'b0110; mk[1] = 16'h66A5;
        fv[2] = 4'b1001; mk[2] = 16'h565A;
        fv[3] = 4'b1010; mk[3] = 16'h6996;

        rst_n = 1'b0; stall_e = 1'b0; flush_e = 1'b0; alu_flags_e = 4'b0000;
        set_dec(1, COND_EQ, ALU_ADD, 2'b11, 1, 1, 1, 1, 1, 1, 1);
        expect_e("reset", 4'b0000, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0);
        tick_check();
`ifdef PERF_CNT_EN
        check("reset.squash", squash_cnt, 16'd0);
`endif
        rst_n = 1'b1;

        // Condition sweep over all 16 codes for four flag patterns
        for (int k = 0; k < 4; k++) begin
            set_dec(1, COND_AL, ALU_BUFFER, 2'b11, 0, 0, 0, 0, 0, 0, 0);
            alu_flags_e = fv[k];
            tick();
            for (int c = 0; c < 16; c++) begin
                m = mk[k];
                set_dec(1, 4'(c), ALU_ADD, 2'b00, 0, 0, 1, 0, 0, 0, 0);
                expect_e($sformatf("sweep_f%b_c%0d", fv[k], c), fv[k], m[c], m[c],
                         0, 0, 0, ALU_ADD, 0, 0, 0);
                tick_check();
            end
        end

        // ADDS sets Z, BEQ sees it with no bubble
        set_dec(1, COND_AL, ALU_ADD, 2'b11, 1, 0, 1, 0, 0, 0, 0);
        alu_flags_e = 4'b0100;
        expect_e("adds", 4'b1010, 1, 1, 0, 0, 0, ALU_ADD, 1, 0, 0);
        tick_check();
`ifdef PERF_CNT_EN
        check("sweep.squash", squash_cnt, 16'd32);
`endif
        set_dec(1, COND_EQ, ALU_NOP, 2'b00, 0, 0, 0, 0, 1, 1, 0);
        expect_e("beq", 4'b0100, 1, 0, 0, 1, 1, ALU_NOP, 0, 0, 0);
        tick_check();

        // STR NE with Z clear, then with Z set
        set_dec(1, COND_AL, ALU_BUFFER, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        alu_flags_e = 4'b0000;
        expect_e("clrz", 4'b0100, 1, 0, 0, 0, 0, ALU_BUFFER, 0, 0, 0);
        tick_check();
        set_dec(1, COND_NE, ALU_ADD, 2'b00, 1, 0, 0, 0, 0, 0, 1);
        expect_e("str_ne_pass", 4'b0000, 1, 0, 1, 0, 0, ALU_ADD, 1, 0, 0);
        tick_check();
        set_dec(1, COND_AL, ALU_BUFFER, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        alu_flags_e = 4'b0100;
        expect_e("setz", 4'b0000, 1, 0, 0, 0, 0, ALU_BUFFER, 0, 0, 0);
        tick_check();
        set_dec(1, COND_NE, ALU_ADD, 2'b00, 1, 0, 0, 0, 0, 0, 1);
        expect_e("str_ne_fail", 4'b0100, 0, 0, 0, 0, 0, ALU_ADD, 1, 0, 0);
        tick_check();
        set_dec(0, COND_AL, ALU_NOP, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        expect_e("idle", 4'b0100, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0);
        tick_check();
`ifdef PERF_CNT_EN
        check("str.squash", squash_cnt, 16'd33);
`endif

        // SUBS held for three stalled edges
        set_dec(1, COND_AL, ALU_SUB, 2'b11, 0, 1, 1, 1, 0, 0, 0);
        alu_flags_e = 4'b1000;
        expect_e("subs", 4'b0100, 1, 1, 0, 0, 0, ALU_SUB, 0, 1, 1);
        tick_check();
        stall_e = 1'b1;
        set_dec(1, COND_NE, ALU_MULT, 2'b00, 1, 0, 0, 0, 1, 1, 1);
        for (int i = 0; i < 3; i++) begin
            expect_e($sformatf("subs_stall%0d", i), 4'b0100, 1, 1, 0, 0, 0, ALU_SUB, 0, 1, 1);
            tick_check();
        end
        stall_e = 1'b0;
        set_dec(0, COND_AL, ALU_NOP, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        expect_e("subs_retire", 4'b1000, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0);
        tick_check();
        set_dec(1, COND_MI, ALU_ADD, 2'b00, 0, 0, 1, 0, 0, 0, 0);
        expect_e("mi_after", 4'b1000, 1, 1, 0, 0, 0, ALU_ADD, 0, 0, 0);
        tick_check();

        // Flush wins over stall; flush alone also bubbles
        set_dec(1, COND_AL, ALU_ADD, 2'b00, 0, 0, 1, 0, 1, 1, 1);
        expect_e("all_ctrl", 4'b1000, 1, 1, 1, 1, 1, ALU_ADD, 0, 0, 0);
        tick_check();
        stall_e = 1'b1; flush_e = 1'b1;
        set_dec(1, COND_AL, ALU_SUB, 2'b00, 1, 1, 1, 1, 1, 1, 1);
        expect_e("stall_flush", 4'b1000, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0);
        tick_check();
        stall_e = 1'b0;
        expect_e("flush", 4'b1000, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0);
        tick_check();
        flush_e = 1'b0;
`ifdef PERF_CNT_EN
        check("flush.squash", squash_cnt, 16'd33);
`endif

        // Reset while stalled with flags 1111
        set_dec(1, COND_AL, ALU_BUFFER, 2'b11, 0, 0, 0, 0, 0, 0, 0);
        alu_flags_e = 4'b1111;
        expect_e("set1111", 4'b1000, 1, 0, 0, 0, 0, ALU_BUFFER, 0, 0, 0);
        tick_check();
        set_dec(1, COND_AL, ALU_ADD, 2'b00, 1, 0, 1, 0, 0, 0, 0);
        expect_e("pre_rst", 4'b1111, 1, 1, 0, 0, 0, ALU_ADD, 1, 0, 0);
        tick_check();
        stall_e = 1'b1;
        expect_e("pre_rst_stall", 4'b1111, 1, 1, 0, 0, 0, ALU_ADD, 1, 0, 0);
        tick_check();
        rst_n = 1'b0;
        expect_e("rst_mid_stall", 4'b0000, 1, 0, 0, 0, 0, ALU_NOP, 0, 0, 0);
        tick_check();
`ifdef PERF_CNT_EN
        check("rst.squash", squash_cnt, 16'd0);
`endif
        rst_n = 1'b1; stall_e = 1'b0;

`ifdef PERF_CNT_EN
        // Fill the counter to 0xFFFE with NV instructions, then three more
        set_dec(1, 4'b1111, ALU_NOP, 2'b00, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("nv.cond_ok", 16'(cond_ok_e), 16'd0);
        repeat (65534) tick();
        check("sat.fffe", squash_cnt, 16'hFFFE);
        repeat (3) tick();
        check("sat.ffff", squash_cnt, 16'hFFFF);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
